pl1_trigger_monitor: RTL and testbench

Receive-side checker for the simulated PL1 trigger stream. It samples a single-bit trigger line and measures each pulse's high width and the rising-edge-to-rising-edge interval, comparing both against programmed expected values. Per-pulse results, error flags and a running pulse count go to the readout/monitoring logic. It sits on the far end of the PL1 trigger generator output, on the same clock.

---
 rtl/pl1_mon_pkg.sv | 21 ++
 rtl/pl1_edge_det.sv | 32 +++
 rtl/pl1_trigger_monitor.sv | 137 +++++++++++++
 tb/tb_pl1_trigger_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pl1_mon_pkg.sv
// pl1_mon_pkg: definitions shared by the PL1 trigger generator and the
// receive-side monitor.
//   mon_state_t    : monitor FSM states
//   DEFAULT_CNT_W  : default width of the width/interval/expected counters
//   DEFAULT_CNT_PW : default width of the pulse counter
//   CNT_MAX        : saturation value of a default-width counter
package pl1_mon_pkg;

  localparam int unsigned DEFAULT_CNT_W  = 16;
  localparam int unsigned DEFAULT_CNT_PW = 32;
  localparam int unsigned CNT_MAX        = 2**DEFAULT_CNT_W - 1;

  // IDLE: no reference rising edge; HIGH: inside a pulse;
  // LOW: between pulses with a reference edge held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/pl1_edge_det.sv
// pl1_edge_det: rise/fall detector for the PL1 trigger line.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   ena        : enable; while low the history register is cleared and
//                no edges are reported
//   trigger_in : trigger line, synchronous to clk
//   rise, fall : combinational edge indications for the current sample
module pl1_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic trigger_in,
  output logic rise,
  output logic fall
);

  logic trig_d;

  always_ff @(posedge clk) begin
    if (!rst || !ena) begin
      trig_d <= 1'b0;
    end else begin
      trig_d <= trigger_in;
    end
  end

  // Clearing trig_d while disabled makes a line that is already high at
  // re-enable count as a rise.
  assign rise = ena &&  trigger_in && !trig_d;
  assign fall = ena && !trigger_in &&  trig_d;

endmodule

// File: rtl/pl1_trigger_monitor.sv
// pl1_trigger_monitor: receive-side checker for the PL1 trigger stream.
// Measures each pulse's high width and its rising-to-rising interval and
// compares them with programmed expectations.
//   clk, rst                 : clock, synchronous active-low reset
//   ena                      : monitor enable (low discards a pulse in flight)
//   trigger_in               : trigger line
//   exp_width, exp_period    : expected width / interval, sampled at the fall
//   pulse_valid              : one-cycle strobe qualifying the result fields
//   pulse_width, interval    : measured width / interval of the last pulse
//   interval_valid           : a previous rising edge existed for interval
//   width_err, interval_err  : mismatch flags, qualified by pulse_valid
//   err_sticky               : any reported error since reset
//   stuck_high               : width counter saturated in the current pulse
//   pulse_count              : completed pulses, wrapping
module pl1_trigger_monitor
  import pl1_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = DEFAULT_CNT_W,
  parameter int unsigned CNT_PW = DEFAULT_CNT_PW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              trigger_in,
  input  logic [CNT_W-1:0]  exp_width,
  input  logic [CNT_W-1:0]  exp_period,
  output logic              pulse_valid,
  output logic [CNT_W-1:0]  pulse_width,
  output logic [CNT_W-1:0]  interval,
  output logic              interval_valid,
  output logic              width_err,
  output logic              interval_err,
  output logic              err_sticky,
  output logic              stuck_high,
  output logic [CNT_PW-1:0] pulse_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT = '1;

  mon_state_t       state;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] intv_cnt;
  logic [CNT_W-1:0] intv_lat;
  logic             ref_valid;
  logic [CNT_W-1:0] width_inc;
  logic [CNT_W-1:0] intv_inc;

  pl1_edge_det u_edge_det (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .trigger_in (trigger_in),
    .rise       (rise),
    .fall       (fall)
  );

  // Saturating increments: counters stick at all-ones and never wrap.
  assign width_inc = (width_cnt == SAT) ? SAT : width_cnt + ONE;
  assign intv_inc  = (intv_cnt  == SAT) ? SAT : intv_cnt  + ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      width_cnt      <= '0;
      intv_cnt       <= '0;
      intv_lat       <= '0;
      ref_valid      <= 1'b0;
      pulse_valid    <= 1'b0;
      pulse_width    <= '0;
      interval       <= '0;
      interval_valid <= 1'b0;
      width_err      <= 1'b0;
      interval_err   <= 1'b0;
      err_sticky     <= 1'b0;
      stuck_high     <= 1'b0;
      pulse_count    <= '0;
    end else begin
      pulse_valid <= 1'b0;
      // Flags are registered with pulse_valid, so the sticky bit folds them
      // in one cycle after the report.
      err_sticky  <= err_sticky | (pulse_valid & (width_err | interval_err));

      if (!ena) begin
        state      <= IDLE;
        ref_valid  <= 1'b0;
        stuck_high <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              width_cnt <= ONE;
              intv_cnt  <= ONE;
              ref_valid <= 1'b0;
              state     <= HIGH;
            end
          end
          LOW: begin
            if (rise) begin
              intv_lat  <= intv_cnt;
              ref_valid <= 1'b1;
              width_cnt <= ONE;
              intv_cnt  <= ONE;
              state     <= HIGH;
            end else begin
              intv_cnt <= intv_inc;
            end
          end
          HIGH: begin
            if (fall) begin
              pulse_valid    <= 1'b1;
              pulse_width    <= width_cnt;
              interval       <= intv_lat;
              interval_valid <= ref_valid;
              width_err      <= (width_cnt != exp_width);
              interval_err   <= ref_valid && (intv_lat != exp_period);
              pulse_count    <= pulse_count + CNT_PW'(1);
              intv_cnt       <= intv_inc;
              stuck_high     <= 1'b0;
              state          <= LOW;
            end else begin
              width_cnt <= width_inc;
              intv_cnt  <= intv_inc;
              if (width_inc == SAT) begin
                stuck_high <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pl1_trigger_monitor.sv
// Directed and randomized bench for pl1_trigger_monitor. The reference model
// works from rising-edge timestamps and high-sample counts of the driven
// waveform rather than from the monitor's internal counters.
module tb_pl1_trigger_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        trigger_in;
  logic [15:0] exp_width;
  logic [15:0] exp_period;
  logic        pulse_valid;
  logic [15:0] pulse_width;
  logic [15:0] interval;
  logic        interval_valid;
  logic        width_err;
  logic        interval_err;
  logic        err_sticky;
  logic        stuck_high;
  logic [31:0] pulse_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  int          cyc = 0;
  bit          m_prev, m_inp, m_have, m_ref_ok;
  int          m_last, m_hi;
  logic [15:0] m_lat;
  bit          m_pv, m_iv, m_werr, m_ierr, m_sticky, m_stuck;
  logic [15:0] m_w, m_int;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pl1_trigger_monitor #(.CNT_W(16), .CNT_PW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .trigger_in     (trigger_in),
    .exp_width      (exp_width),
    .exp_period     (exp_period),
    .pulse_valid    (pulse_valid),
    .pulse_width    (pulse_width),
    .interval       (interval),
    .interval_valid (interval_valid),
    .width_err      (width_err),
    .interval_err   (interval_err),
    .err_sticky     (err_sticky),
    .stuck_high     (stuck_high),
    .pulse_count    (pulse_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_prev = 0; m_inp = 0; m_have = 0; m_ref_ok = 0; m_last = 0; m_hi = 0;
    m_lat = '0; m_pv = 0; m_iv = 0; m_werr = 0; m_ierr = 0; m_sticky = 0;
    m_stuck = 0; m_w = '0; m_int = '0; m_cnt = '0;
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic step(input bit t, input bit e, input bit r, input bit c);
    int d;
    trigger_in = t; ena = e; rst = r;
    @(posedge clk); #1;
    cyc++;
    if (!r) begin
      model_clear();
    end else begin
      m_sticky = m_sticky | (m_pv & (m_werr | m_ierr));
      m_pv = 0;
      if (!e) begin
        m_prev = 0; m_inp = 0; m_have = 0; m_stuck = 0;
      end else begin
        if (t && !m_prev) begin
          m_ref_ok = m_have;
          if (m_have) begin
            d = cyc - m_last;
            m_lat = (d > 65535) ? 16'hFFFF : 16'(d);
          end
          m_last = cyc; m_have = 1; m_inp = 1; m_hi = 1;
        end else if (t && m_inp) begin
          m_hi = (m_hi < 65535) ? m_hi + 1 : 65535;
          if (m_hi == 65535) m_stuck = 1;
        end else if (!t && m_prev && m_inp) begin
          m_pv = 1; m_w = 16'(m_hi); m_int = m_lat; m_iv = m_ref_ok;
          m_werr = (16'(m_hi) != exp_width);
          m_ierr = m_ref_ok && (m_lat != exp_period);
          m_cnt = m_cnt + 1; m_stuck = 0; m_inp = 0;
        end
        m_prev = t;
      end
    end
    if (c) begin
      chk("pulse_valid", pulse_valid, m_pv);
      chk("pulse_count", pulse_count, m_cnt);
      chk("err_sticky", err_sticky, m_sticky);
      chk("stuck_high", stuck_high, m_stuck);
      chk("pulse_width", pulse_width, m_w);
      chk("interval_valid", interval_valid, m_iv);
      if (m_pv) begin
        chk("width_err", width_err, m_werr);
        chk("interval_err", interval_err, m_ierr);
        if (m_iv) chk("interval", interval, m_int);
      end
      if (!r) begin
        chk("rst_interval", interval, 0);
        chk("rst_width_err", width_err, 0);
        chk("rst_interval_err", interval_err, 0);
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1, 1, 1, 1);
    for (int i = 0; i < lo; i++) step(0, 1, 1, 1);
  endtask

  initial begin
    rst = 0; ena = 1; trigger_in = 0; exp_width = 16'd9; exp_period = 16'd100;
    model_clear();

    // Reset, with ena high and the line toggling
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);

    // Single pulse, then matching 100-cycle interval
    pulse(9, 91);
    chk("first_count", pulse_count, 1);
    pulse(9, 91);
    // Interval mismatch sets the sticky flag
    exp_period = 16'd99;
    pulse(9, 91);
    pulse(9, 5);
    chk("sticky_after_mismatch", err_sticky, 1);

    // Randomized pulses, expectations and occasional enable drops
    for (int p = 0; p < 60; p++) begin
      int hi, lo, drop_at;
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      exp_width  = 16'($urandom_range(1, 12));
      exp_period = 16'($urandom_range(2, 24));
      drop_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hi - 1) : -1;
      for (int j = 0; j < hi; j++) begin
        if (j == drop_at) begin
          step(1, 0, 1, 1);
          step(1, 0, 1, 1);
        end
        step(1, 1, 1, 1);
      end
      for (int j = 0; j < lo; j++) step(0, 1, 1, 1);
    end

    // Enable dropped after 4 high samples: no report, reference lost
    exp_width = 16'd9; exp_period = 16'd10;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    pulse(9, 5);
    chk("after_drop_ivalid", interval_valid, 0);

    // Reset in the middle of a pulse with the sticky flag set
    chk("sticky_before_rst", err_sticky, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    chk("rst_count", pulse_count, 0);
    pulse(9, 5);
    pulse(9, 3);

    // Back-to-back 9 high / 1 low
    exp_width = 16'd9; exp_period = 16'd10;
    for (int i = 0; i < 8; i++) pulse(9, 1);
    step(0, 1, 1, 1);
    chk("b2b_interval", interval, 10);

    // Stuck-high saturation
    exp_width = 16'hFFFF;
    for (int i = 0; i < 70000; i++)
      step(1, 1, 1, (i < 3) || (i >= 65530 && i < 65540) || (i == 69999));
    chk("stuck_set", stuck_high, 1);
    step(0, 1, 1, 1);
    chk("sat_width", pulse_width, 16'hFFFF);
    step(0, 1, 1, 1);
    chk("stuck_cleared", stuck_high, 0);
    pulse(3, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
